// File: rtl/irq_ctrl_multi_pkg.sv
// Shared definitions for the vectored interrupt controller: vector layout,
// controller FSM states and well-known source indices.
package irq_ctrl_multi_pkg;

    localparam logic [31:0] DEF_VEC_BASE   = 32'h0000_0100;
    localparam logic [31:0] DEF_VEC_STRIDE = 32'h0000_0010;

    localparam int unsigned SRC_SYSCALL = 0;
    localparam int unsigned SRC_BUTTON  = 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } irq_state_e;

    // Vector address of a source; arithmetic wraps modulo 2^32.
    function automatic logic [31:0] vec_addr(input logic [31:0] base,
                                             input logic [31:0] stride,
                                             input int unsigned src);
        return base + src * stride;
    endfunction

endpackage

// File: rtl/irq_ctrl_multi_prio.sv
// Fixed-priority find-first-set: index 0 wins; valid_o when any bit is set.
module prio_enc #(
    parameter int unsigned N = 4,
    parameter int unsigned W = $clog2(N)
) (
    input  logic [N-1:0] req_i,
    output logic         valid_o,
    output logic [W-1:0] idx_o
);

    always_comb begin
        idx_o = '0;
        for (int unsigned i = N; i > 0; i--) begin
            if (req_i[i-1]) idx_o = W'(i - 1);
        end
        valid_o = |req_i;
    end

endmodule

// File: rtl/irq_ctrl_multi.sv
// N-source vectored interrupt controller: edge-latched pending set, mask,
// fixed-priority arbitration with optional nesting, req/ack handoff and RTI retire.
module irq_ctrl_multi
    import irq_ctrl_multi_pkg::*;
#(
    parameter int unsigned N_SRC      = 4,
    parameter int unsigned MAX_NEST   = 2,
    parameter bit          NEST_EN    = 1'b1,
    parameter logic [31:0] VEC_BASE   = DEF_VEC_BASE,
    parameter logic [31:0] VEC_STRIDE = DEF_VEC_STRIDE,
    localparam int unsigned SW        = $clog2(N_SRC)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_SRC-1:0] irq_in,
    input  logic             mask_we,
    input  logic [N_SRC-1:0] mask_wdata,
    input  logic             int_ack,
    input  logic             rti,
    output logic             int_req,
    output logic [31:0]      int_id,
    output logic [SW-1:0]    int_src,
    output logic [N_SRC-1:0] pending,
    output logic [N_SRC-1:0] in_service,
    output logic [SW:0]      nest_level,
    output logic             rti_err
);

    localparam int unsigned NW = SW + 1;

    irq_state_e       state_q, state_d;
    logic [N_SRC-1:0] irq_d_q;
    logic [N_SRC-1:0] mask_q;
    logic [N_SRC-1:0] pending_q, pending_d;
    logic [N_SRC-1:0] in_service_q, in_service_d;
    logic [NW-1:0]    nest_q, nest_d;
    logic [SW-1:0]    int_src_q, int_src_d;
    logic [31:0]      int_id_q, int_id_d;
    logic             rti_err_q;

    logic [N_SRC-1:0] rise, below_top, eligible, src_onehot, top_onehot;
    logic             top_valid, cand_valid, nest_ok, ack_ok, rti_ok;
    logic [SW-1:0]    top_idx, cand_idx;

    prio_enc #(.N(N_SRC), .W(SW)) u_top (
        .req_i   (in_service_q),
        .valid_o (top_valid),
        .idx_o   (top_idx)
    );

    prio_enc #(.N(N_SRC), .W(SW)) u_cand (
        .req_i   (eligible),
        .valid_o (cand_valid),
        .idx_o   (cand_idx)
    );

    assign rise    = irq_in & ~irq_d_q;
    assign ack_ok  = (state_q == ST_REQ) && int_ack;
    assign rti_ok  = rti && top_valid;
    assign nest_ok = (nest_q < NW'(MAX_NEST)) && (NEST_EN || !(|in_service_q));

    always_comb begin
        below_top  = '0;
        src_onehot = '0;
        top_onehot = '0;
        for (int unsigned i = 0; i < N_SRC; i++) begin
            below_top[i]  = !top_valid || (i < 32'(top_idx));
            src_onehot[i] = (i == 32'(int_src_q));
            top_onehot[i] = (i == 32'(top_idx));
        end
        eligible = pending_q & ~mask_q & below_top & {N_SRC{nest_ok}};
    end

    // rti retires the top of the pre-ack set; the acked source is always
    // below that top, so clear-then-set never touches the same bit.
    always_comb begin
        pending_d    = (pending_q & ~(ack_ok ? src_onehot : '0)) | rise;
        in_service_d = (in_service_q & ~(rti_ok ? top_onehot : '0))
                     | (ack_ok ? src_onehot : '0);
        unique case ({ack_ok, rti_ok})
            2'b10:   nest_d = nest_q + NW'(1);
            2'b01:   nest_d = nest_q - NW'(1);
            default: nest_d = nest_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (cand_valid) state_d = ST_REQ;
            ST_REQ:  if (int_ack)    state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        int_req   = (state_q == ST_REQ);
        int_src_d = int_src_q;
        int_id_d  = int_id_q;
        if (state_q == ST_IDLE && cand_valid) begin
            int_src_d = cand_idx;
            int_id_d  = vec_addr(VEC_BASE, VEC_STRIDE, 32'(cand_idx));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_d_q      <= '0;
            mask_q       <= '1;
            pending_q    <= '0;
            in_service_q <= '0;
            nest_q       <= '0;
            int_src_q    <= '0;
            int_id_q     <= '0;
            rti_err_q    <= 1'b0;
        end else begin
            irq_d_q      <= irq_in;
            if (mask_we) mask_q <= mask_wdata;
            pending_q    <= pending_d;
            in_service_q <= in_service_d;
            nest_q       <= nest_d;
            int_src_q    <= int_src_d;
            int_id_q     <= int_id_d;
            rti_err_q    <= rti && !top_valid;
        end
    end

    assign int_id     = int_id_q;
    assign int_src    = int_src_q;
    assign pending    = pending_q;
    assign in_service = in_service_q;
    assign nest_level = nest_q;
    assign rti_err    = rti_err_q;

endmodule

// File: tb/tb_irq_ctrl_multi.sv
// Bench for irq_ctrl_multi: directed scenarios followed by random traffic,
// all checked against a cycle-level behavioural model of the controller.
module tb_irq_ctrl_multi;

    localparam int          N      = 4;
    localparam int          SW     = 2;
    localparam int          MAXN   = 2;
    localparam logic [31:0] BASE   = 32'h0000_0100;
    localparam logic [31:0] STRIDE = 32'h0000_0010;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  irq_in;
    logic          mask_we;
    logic [N-1:0]  mask_wdata;
    logic          int_ack;
    logic          rti;
    logic          int_req;
    logic [31:0]   int_id;
    logic [SW-1:0] int_src;
    logic [N-1:0]  pending;
    logic [N-1:0]  in_service;
    logic [SW:0]   nest_level;
    logic          rti_err;

    int errors = 0;
    int checks = 0;

    // model state
    bit [N-1:0]  m_prev, m_pend, m_mask, m_insvc;
    bit          m_req, m_err;
    int          m_src;
    logic [31:0] m_id;

    irq_ctrl_multi #(
        .N_SRC      (N),
        .MAX_NEST   (MAXN),
        .NEST_EN    (1'b1),
        .VEC_BASE   (BASE),
        .VEC_STRIDE (STRIDE)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .irq_in     (irq_in),
        .mask_we    (mask_we),
        .mask_wdata (mask_wdata),
        .int_ack    (int_ack),
        .rti        (rti),
        .int_req    (int_req),
        .int_id     (int_id),
        .int_src    (int_src),
        .pending    (pending),
        .in_service (in_service),
        .nest_level (nest_level),
        .rti_err    (rti_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_prev = '0; m_pend = '0; m_mask = '1; m_insvc = '0;
        m_req = 0; m_err = 0; m_src = 0; m_id = '0;
    endtask

    task automatic model_step();
        int         cnt = 0;
        int         top = N;
        int         cand = -1;
        bit         ack, rok;
        bit [N-1:0] rise, np, ni;
        bit         nreq;
        if (!rst_n) begin
            model_reset();
            return;
        end
        for (int i = 0; i < N; i++) if (m_insvc[i]) cnt++;
        for (int i = N - 1; i >= 0; i--) if (m_insvc[i]) top = i;
        rise = irq_in & ~m_prev;
        ack  = m_req && int_ack;
        rok  = rti && cnt > 0;
        nreq = m_req;
        if (!m_req) begin
            if (cnt < MAXN)
                for (int i = 0; i < N; i++)
                    if (cand < 0 && m_pend[i] && !m_mask[i] && i < top) cand = i;
            if (cand >= 0) begin
                nreq  = 1;
                m_src = cand;
                m_id  = BASE + 32'(cand) * STRIDE;
            end
        end else if (ack) begin
            nreq = 0;
        end
        np = m_pend;
        ni = m_insvc;
        if (ack) begin
            np[m_src] = 0;
            ni[m_src] = 1;
        end
        if (rok) ni[top] = 0;
        m_pend  = np | rise;
        m_insvc = ni;
        m_req   = nreq;
        if (mask_we) m_mask = mask_wdata;
        m_err   = rti && cnt == 0;
        m_prev  = irq_in;
    endtask

    task automatic check_all();
        chk("int_req",    32'(int_req),    32'(m_req));
        chk("int_id",     int_id,          m_id);
        chk("int_src",    32'(int_src),    32'(m_src));
        chk("pending",    32'(pending),    32'(m_pend));
        chk("in_service", 32'(in_service), 32'(m_insvc));
        chk("nest_level", 32'(nest_level), 32'($countones(m_insvc)));
        chk("rti_err",    32'(rti_err),    32'(m_err));
    endtask

    // Inputs change at negedge; model advances at posedge; outputs checked 1 later.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_all();
        @(negedge clk);
    endtask

    task automatic pulse_ack();
        int_ack = 1; tick(); int_ack = 0;
    endtask

    task automatic pulse_rti();
        rti = 1; tick(); rti = 0;
    endtask

    task automatic write_mask(input logic [N-1:0] m);
        mask_we = 1; mask_wdata = m; tick(); mask_we = 0;
    endtask

    initial begin
        rst_n = 0; irq_in = '0; mask_we = 0; mask_wdata = '0; int_ack = 0; rti = 0;
        model_reset();
        #12;
        check_all();
        @(negedge clk);
        rst_n = 1;

        // 1) single source latency and vector
        write_mask('0);
        irq_in = 4'b0010; tick();
        chk("t1_pending_k", 32'(pending), 32'h2);
        chk("t1_noreq_k",   32'(int_req), 32'h0);
        irq_in = '0; tick();
        chk("t1_req",  32'(int_req), 32'h1);
        chk("t1_id",   int_id,       32'h110);
        chk("t1_src",  32'(int_src), 32'h1);

        // 2) ack then rti
        pulse_ack();
        chk("t2_insvc", 32'(in_service), 32'h2);
        chk("t2_nest",  32'(nest_level), 32'h1);
        pulse_rti();
        chk("t2_insvc0", 32'(in_service), 32'h0);
        chk("t2_noerr",  32'(rti_err),    32'h0);

        // 3) priority, preemption, nest limit
        irq_in = 4'b1010; tick();
        irq_in = '0; tick();
        chk("t3_first_src", 32'(int_src), 32'h1);
        pulse_ack();
        irq_in = 4'b0001; tick();
        irq_in = '0; tick();
        chk("t3_preempt_id", int_id, 32'h100);
        pulse_ack();
        chk("t3_nest2", 32'(nest_level), 32'h2);
        tick(); tick();
        chk("t3_src3_waits", 32'(int_req), 32'h0);
        pulse_rti();
        tick();
        chk("t3_still_waits", 32'(int_req), 32'h0);
        pulse_rti();
        chk("t3_idle_after_rti", 32'(int_req), 32'h0);
        tick();
        chk("t3_src3_req", 32'(int_src), 32'h3);
        chk("t3_src3_id",  int_id,       32'h130);
        pulse_ack();
        pulse_rti();

        // 4) masked source latches but does not request
        write_mask(4'b0001);
        irq_in = 4'b0001; tick();
        irq_in = '0; tick(); tick();
        chk("t4_pending", 32'(pending), 32'h1);
        chk("t4_noreq",   32'(int_req), 32'h0);
        write_mask('0);
        chk("t4_noreq_at_we", 32'(int_req), 32'h0);
        tick();
        chk("t4_req", 32'(int_req), 32'h1);
        pulse_ack();
        pulse_rti();

        // 5) request held across higher arrival and self-mask
        irq_in = 4'b0100; tick();
        irq_in = '0; tick();
        irq_in = 4'b0001; mask_we = 1; mask_wdata = 4'b0100; tick();
        irq_in = '0; mask_we = 0; tick(); tick();
        chk("t5_held_id", int_id,       32'h120);
        chk("t5_held_rq", 32'(int_req), 32'h1);
        pulse_ack();
        chk("t5_drop_at_m", 32'(int_req), 32'h0);
        tick();
        chk("t5_next_src", 32'(int_src), 32'h0);
        chk("t5_next_id",  int_id,       32'h100);
        pulse_ack();
        pulse_rti();
        pulse_rti();

        // 6) spurious rti, then async reset mid-request
        pulse_rti();
        chk("t6_rti_err", 32'(rti_err), 32'h1);
        tick();
        chk("t6_rti_err_clr", 32'(rti_err), 32'h0);
        write_mask('0);
        irq_in = 4'b1000; tick();
        irq_in = '0; tick();
        chk("t6_req_before_rst", 32'(int_req), 32'h1);
        #2 rst_n = 0;
        #1;
        model_reset();
        chk("t6_async_drop", 32'(int_req), 32'h0);
        check_all();
        @(negedge clk);
        tick();
        rst_n = 1;

        // random traffic
        for (int n = 0; n < 400; n++) begin
            irq_in     = N'($urandom);
            mask_we    = ($urandom_range(0, 7) == 0);
            mask_wdata = N'($urandom & $urandom);
            int_ack    = ($urandom_range(0, 2) == 0);
            rti        = ($urandom_range(0, 4) == 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout: simulation exceeded time limit");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
